// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing controller: steps each instruction through IF/ID/EX/MEM/WB,
// drives the shared-datapath strobes and selects, and counts retired instructions.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             ExtOp,
    output logic             LuOp,
    output logic [2:0]       State,
    output logic [CNT_W-1:0] RetireCnt
);

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    logic [2:0]       State_q, State_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    logic is_r, is_shift, is_ralu, is_ialu, is_lw, is_sw;
    logic is_beq, is_j, is_jal, is_jr, is_jalr, supported;

    // Instruction class decode from the IR fields.
    always_comb begin
        is_r     = (OpCode == OP_R);
        is_shift = is_r && ((Funct == FN_SLL) || (Funct == FN_SRL) || (Funct == FN_SRA));
        is_ralu  = is_r && ((Funct[5:3] == 3'b100) || is_shift ||
                            (Funct == FN_SLT) || (Funct == FN_SLTU));
        is_jr    = is_r && (Funct == FN_JR);
        is_jalr  = is_r && (Funct == FN_JALR);
        is_ialu  = (OpCode == OP_LUI)  || (OpCode == OP_ADDI)  || (OpCode == OP_ADDIU) ||
                   (OpCode == OP_ANDI) || (OpCode == OP_SLTI)  || (OpCode == OP_SLTIU);
        is_lw    = (OpCode == OP_LW);
        is_sw    = (OpCode == OP_SW);
        is_beq   = (OpCode == OP_BEQ);
        is_j     = (OpCode == OP_J);
        is_jal   = (OpCode == OP_JAL);
        supported = is_ralu || is_ialu || is_lw || is_sw || is_beq ||
                    is_j || is_jal || is_jr || is_jalr;
    end

    // Next state and retirement; an unsupported opcode falls back to IF uncounted.
    always_comb begin
        State_d = S_IF;
        retire  = 1'b0;
        case (State_q)
            S_IF: State_d = S_ID;
            S_ID: State_d = supported ? S_EX : S_IF;
            S_EX: begin
                if (is_ralu || is_ialu) begin
                    State_d = S_WB;
                end else if (is_lw || is_sw) begin
                    State_d = S_MEM;
                end else begin
                    State_d = S_IF;
                    retire  = is_beq || is_j || is_jal || is_jr || is_jalr;
                end
            end
            S_MEM: begin
                if (is_lw) begin
                    State_d = S_WB;
                end else begin
                    State_d = S_IF;
                    retire  = is_sw;
                end
            end
            S_WB: begin
                State_d = S_IF;
                retire  = 1'b1;
            end
            default: State_d = S_IF;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (retire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            State_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            State_q <= State_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath controls; everything is held at zero while reset is asserted.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        ExtOp       = 1'b0;
        LuOp        = 1'b0;
        if (!reset) begin
            ExtOp = (OpCode != OP_ANDI);
            LuOp  = (OpCode == OP_LUI);
            case (State_q)
                S_IF: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    ALUSrcB = 2'b01;
                    PCWrite = 1'b1;
                end
                S_ID: ALUSrcB = 2'b11;
                S_EX: begin
                    if (is_ralu) begin
                        ALUSrcA = is_shift ? 2'b10 : 2'b01;
                        ALUOp   = 2'b10;
                    end else if (is_ialu) begin
                        ALUSrcA = 2'b01;
                        ALUSrcB = 2'b10;
                        ALUOp   = 2'b11;
                    end else if (is_lw || is_sw) begin
                        ALUSrcA = 2'b01;
                        ALUSrcB = 2'b10;
                    end else if (is_beq) begin
                        ALUSrcA     = 2'b01;
                        ALUOp       = 2'b01;
                        PCWriteCond = 1'b1;
                        PCSource    = 2'b01;
                    end else if (is_j || is_jal) begin
                        PCWrite  = 1'b1;
                        PCSource = 2'b10;
                    end else if (is_jr || is_jalr) begin
                        PCWrite  = 1'b1;
                        PCSource = 2'b11;
                    end
                    if (is_jal || is_jalr) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b10;
                        MemtoReg = 2'b10;
                    end
                end
                S_MEM: begin
                    if (is_lw) begin
                        MemRead = 1'b1;
                        IorD    = 1'b1;
                    end else if (is_sw) begin
                        MemWrite = 1'b1;
                        IorD     = 1'b1;
                    end
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    if (is_lw) begin
                        MemtoReg = 2'b01;
                    end else if (is_ralu) begin
                        RegDst = 2'b01;
                    end
                end
                default: ;
            endcase
        end
    end

    assign State     = State_q;
    assign RetireCnt = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instructions followed by random
// instruction streams, compared cycle by cycle against a per-class control table.
module tb_multicycle_control;

    localparam int CW = 8;

    localparam int C_UNS  = 0;
    localparam int C_RALU = 1;
    localparam int C_IALU = 2;
    localparam int C_LW   = 3;
    localparam int C_SW   = 4;
    localparam int C_BEQ  = 5;
    localparam int C_J    = 6;
    localparam int C_JAL  = 7;
    localparam int C_JR   = 8;
    localparam int C_JALR = 9;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw, pcwc, iord, mr, mw, irw, rw;
        logic [1:0] regdst, m2r, srca, srcb, aluop, pcsrc;
        logic       extop, luop;
    } ctl_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    OpCode, Funct;
    logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite;
    logic [1:0]    RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource;
    logic          ExtOp, LuOp;
    logic [2:0]    State;
    logic [CW-1:0] RetireCnt;
    ctl_t          obs_c;

    int tests = 0;
    int fails = 0;
    int mcnt  = 0;

    multicycle_control #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .ExtOp(ExtOp), .LuOp(LuOp),
        .State(State), .RetireCnt(RetireCnt)
    );

    always #5 clk = ~clk;

    assign obs_c = {State, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                    RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, ExtOp, LuOp};

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            if (fn inside {[6'h20:6'h27], 6'h00, 6'h02, 6'h03, 6'h2a, 6'h2b}) return C_RALU;
            if (fn == 6'h08) return C_JR;
            if (fn == 6'h09) return C_JALR;
            return C_UNS;
        end
        if (op inside {6'h0f, 6'h08, 6'h09, 6'h0c, 6'h0a, 6'h0b}) return C_IALU;
        case (op)
            6'h23:   return C_LW;
            6'h2b:   return C_SW;
            6'h04:   return C_BEQ;
            6'h02:   return C_J;
            6'h03:   return C_JAL;
            default: return C_UNS;
        endcase
    endfunction

    function automatic int ncyc(input int cls);
        case (cls)
            C_UNS:                return 2;
            C_LW:                 return 5;
            C_SW, C_RALU, C_IALU: return 4;
            default:              return 3;
        endcase
    endfunction

    // Cycle k of an instruction: IF, ID, EX, then MEM or WB (ALU classes skip MEM).
    function automatic logic [2:0] state_at(input int cls, input int k);
        if ((cls == C_RALU || cls == C_IALU) && k == 3) return 3'd4;
        return 3'(k);
    endfunction

    function automatic ctl_t exp_ctl(input int cls, input logic [2:0] st,
                                     input logic [5:0] fn, input logic [5:0] opc);
        ctl_t c = '0;
        c.st    = st;
        c.extop = (opc != 6'h0c);
        c.luop  = (opc == 6'h0f);
        case (st)
            3'd0: begin c.mr = 1; c.irw = 1; c.srcb = 2'b01; c.pcw = 1; end
            3'd1: c.srcb = 2'b11;
            3'd2: case (cls)
                C_RALU: begin
                    c.srca  = (fn inside {6'h00, 6'h02, 6'h03}) ? 2'b10 : 2'b01;
                    c.aluop = 2'b10;
                end
                C_IALU: begin c.srca = 2'b01; c.srcb = 2'b10; c.aluop = 2'b11; end
                C_LW, C_SW: begin c.srca = 2'b01; c.srcb = 2'b10; end
                C_BEQ: begin c.srca = 2'b01; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; end
                C_J:   begin c.pcw = 1; c.pcsrc = 2'b10; end
                C_JAL: begin
                    c.pcw = 1; c.pcsrc = 2'b10; c.rw = 1; c.regdst = 2'b10; c.m2r = 2'b10;
                end
                C_JR:  begin c.pcw = 1; c.pcsrc = 2'b11; end
                C_JALR: begin
                    c.pcw = 1; c.pcsrc = 2'b11; c.rw = 1; c.regdst = 2'b10; c.m2r = 2'b10;
                end
                default: ;
            endcase
            3'd3: begin
                if (cls == C_LW) begin c.mr = 1; c.iord = 1; end
                if (cls == C_SW) begin c.mw = 1; c.iord = 1; end
            end
            3'd4: begin
                c.rw = 1;
                if (cls == C_LW) c.m2r = 2'b01;
                if (cls == C_RALU) c.regdst = 2'b01;
            end
            default: ;
        endcase
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one instruction from IF; abort_k >= 0 raises reset during that cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input string tag, input int abort_k);
        int   cls = classify(op, fn);
        int   n   = ncyc(cls);
        ctl_t e;
        logic [5:0] g;
        for (int k = 0; k < n; k++) begin
            if (k == 0) begin
                g = 6'($urandom);
                if (g == 6'h0c || g == 6'h0f) g = 6'h3f;
                OpCode = g;
                Funct  = 6'($urandom);
            end else begin
                OpCode = op;
                Funct  = fn;
            end
            if (k == abort_k) begin
                reset = 1'b1;
                @(negedge clk);
                e = '0;
                e.st = state_at(cls, k);
                chk({tag, "_rst_ctl"}, 32'(obs_c), 32'(e));
                chk({tag, "_rst_cnt"}, 32'(RetireCnt), 32'(mcnt));
                @(posedge clk); #1;
                mcnt = 0;
                @(negedge clk);
                chk({tag, "_rst_state"}, 32'(obs_c), 32'(0));
                chk({tag, "_rst_cnt0"}, 32'(RetireCnt), 32'(0));
                @(posedge clk); #1;
                reset = 1'b0;
                return;
            end
            @(negedge clk);
            e = exp_ctl(cls, state_at(cls, k), Funct, OpCode);
            chk($sformatf("%s_c%0d", tag, k), 32'(obs_c), 32'(e));
            chk($sformatf("%s_cnt%0d", tag, k), 32'(RetireCnt), 32'(mcnt));
            @(posedge clk); #1;
        end
        if (cls != C_UNS) mcnt = (mcnt + 1) % (1 << CW);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    logic [5:0] ops [12] = '{6'h00, 6'h23, 6'h2b, 6'h0f, 6'h08, 6'h09,
                             6'h0c, 6'h0a, 6'h0b, 6'h04, 6'h02, 6'h03};
    logic [5:0] fns [20] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                             6'h00, 6'h02, 6'h03, 6'h2a, 6'h2b, 6'h08, 6'h09,
                             6'h04, 6'h06, 6'h18, 6'h3f, 6'h01};

    initial begin
        logic [5:0] op, fn;
        int         ab;
        reset  = 1'b1;
        OpCode = 6'h00;
        Funct  = 6'h00;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_ctl", 32'(obs_c), 32'(0));
        chk("reset_cnt", 32'(RetireCnt), 32'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(6'h23, 6'h00, "lw",   -1);
        run_instr(6'h2b, 6'h11, "sw",   -1);
        run_instr(6'h00, 6'h20, "add",  -1);
        run_instr(6'h00, 6'h00, "sll",  -1);
        run_instr(6'h0c, 6'h15, "andi", -1);
        run_instr(6'h04, 6'h00, "beq",  -1);
        run_instr(6'h03, 6'h00, "jal",  -1);
        run_instr(6'h00, 6'h09, "jalr", -1);
        run_instr(6'h3f, 6'h00, "uns3f", -1);
        run_instr(6'h00, 6'h05, "unsfn", -1);
        run_instr(6'h0f, 6'h00, "lui",  -1);
        run_instr(6'h23, 6'h00, "lw_abort", 3);
        run_instr(6'h00, 6'h08, "jr",   -1);

        for (int i = 0; i < 450; i++) begin
            if ($urandom_range(0, 13) < 12) op = ops[$urandom_range(0, 11)];
            else op = 6'($urandom);
            fn = (op == 6'h00) ? fns[$urandom_range(0, 19)] : 6'($urandom);
            ab = -1;
            if ($urandom_range(0, 39) == 0) ab = $urandom_range(0, ncyc(classify(op, fn)) - 1);
            run_instr(op, fn, $sformatf("rnd%0d", i), ab);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
